// File: rtl/ay_bus_sequencer.sv
// ay_bus_sequencer
// Turns decoded CPU accesses to the AY-3-8910 register and data ports into
// timed AY bus cycles. Each cycle is an address latch, a data write or a data
// read, built from BDIR/BC1 phases. The CPU is held in WAIT until the AY side
// of the cycle has finished.
module ay_bus_sequencer #(
  parameter int LATCH_CYC = 4,
  parameter int WR_CYC    = 5,
  parameter int RD_CYC    = 5,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_reg,
  input  logic       cs_data,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] cpu_d,
  output logic [7:0] cpu_q,
  output logic       cpu_oe,
  output logic       wait_n,
  output logic [7:0] ay_d,
  output logic       ay_oe,
  input  logic [7:0] ay_q,
  output logic       bdir,
  output logic       bc1
);

  // The counter has to hold the longest phase length minus one. One spare
  // bit is added on top of that.
  localparam int MAX_A   = (LATCH_CYC > WR_CYC) ? LATCH_CYC : WR_CYC;
  localparam int MAX_B   = (RD_CYC > HOLD_CYC) ? RD_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LATCH = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] CNT_WR    = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] CNT_RD    = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] CNT_HOLD  = CW'(HOLD_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // The transaction type is latched when the cycle starts. DONE needs it to
  // decide whether read data goes back to the CPU.
  localparam logic [1:0] T_LATCH = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_READ  = 2'd2;
  localparam logic [1:0] T_REGRD = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [1:0]    txn_q, txn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ayD_q, ayD_d;
  logic [7:0]    cpuQ_q, cpuQ_d;
  logic          stb;

  assign stb = (cs_reg | cs_data) & (~rd_n | ~wr_n);

  // Next-state logic.
  // Write wins when both strobes are low, and cs_data wins over cs_reg.
  // Strobe changes are ignored until the FSM is back in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    cnt_d   = cnt_q;
    ayD_d   = ayD_q;
    cpuQ_d  = cpuQ_q;
    case (state_q)
      S_IDLE: begin
        if (stb) begin
          ayD_d = cpu_d;
          if (~wr_n) begin
            if (cs_data) begin
              txn_d   = T_WRITE;
              state_d = S_WRITE;
              cnt_d   = CNT_WR;
            end else begin
              txn_d   = T_LATCH;
              state_d = S_LATCH;
              cnt_d   = CNT_LATCH;
            end
          end else if (cs_data) begin
            txn_d   = T_READ;
            state_d = S_READ;
            cnt_d   = CNT_RD;
          end else begin
            txn_d   = T_REGRD;
            cpuQ_d  = 8'hFF;
            state_d = S_DONE;
          end
        end
      end
      S_LATCH, S_WRITE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          cpuQ_d  = ay_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (!stb) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset. A reset in the middle of a
  // cycle drops the AY phase at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      txn_q   <= T_LATCH;
      cnt_q   <= '0;
      ayD_q   <= 8'h00;
      cpuQ_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      cnt_q   <= cnt_d;
      ayD_q   <= ayD_d;
      cpuQ_q  <= cpuQ_d;
    end
  end

  // Bus outputs are decoded from the registered state only. In HOLD,
  // BDIR/BC1 are already inactive while ay_oe is still high.
  assign bdir   = (state_q == S_LATCH) || (state_q == S_WRITE);
  assign bc1    = (state_q == S_LATCH) || (state_q == S_READ);
  assign ay_oe  = (state_q == S_LATCH) || (state_q == S_WRITE) || (state_q == S_HOLD);
  assign wait_n = !((state_q == S_LATCH) || (state_q == S_WRITE) ||
                    (state_q == S_READ)  || (state_q == S_HOLD));
  assign cpu_oe = (state_q == S_DONE) && ((txn_q == T_READ) || (txn_q == T_REGRD)) && !rd_n;
  assign ay_d   = ayD_q;
  assign cpu_q  = cpuQ_q;

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// tb_ay_bus_sequencer
// Directed bench for ay_bus_sequencer. The bus signature {bdir, bc1, ay_oe,
// wait_n, cpu_oe} is checked on every clock of each transaction. The
// expected values come from hand-derived phase lengths.
module tb_ay_bus_sequencer;

  logic       clk;
  logic       reset;
  logic       csReg;
  logic       csData;
  logic       rdN;
  logic       wrN;
  logic [7:0] cpuD;
  logic [7:0] cpuQ;
  logic       cpuOe;
  logic       waitN;
  logic [7:0] ayD;
  logic       ayOe;
  logic [7:0] ayQ;
  logic       bdir;
  logic       bc1;

  int vectors;
  int miscompares;

  ay_bus_sequencer #(
    .LATCH_CYC(4),
    .WR_CYC(5),
    .RD_CYC(5),
    .HOLD_CYC(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs_reg(csReg),
    .cs_data(csData),
    .rd_n(rdN),
    .wr_n(wrN),
    .cpu_d(cpuD),
    .cpu_q(cpuQ),
    .cpu_oe(cpuOe),
    .wait_n(waitN),
    .ay_d(ayD),
    .ay_oe(ayOe),
    .ay_q(ayQ),
    .bdir(bdir),
    .bc1(bc1)
  );

  // 10 MHz clock
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Single comparison point: counts every vector and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the CPU-side inputs
  task automatic applyStimulus(input logic r, input logic d, input logic rn, input logic wn,
                               input logic [7:0] data);
    csReg  = r;
    csData = d;
    rdN    = rn;
    wrN    = wn;
    cpuD   = data;
  endtask

  // Step one clock and sample 1 ns after the rising edge
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Run n clocks with the current stimulus held. Each clock is compared
  // against the expected signature:
  //   - an active phase of a clocks with bdir/bc1/ay_oe = bE/cE/oE,
  //   - then h hold clocks,
  //   - then DONE, with cpu_oe = rdE.
  // ay_d is compared while ay_oe is expected high.
  task automatic runTxn(input string tag, input int n, input int a, input int h,
                        input logic bE, input logic cE, input logic oE, input logic rdE,
                        input logic [7:0] dE);
    int waitLow;
    logic [4:0] expSig;
    waitLow = 0;
    for (int i = 0; i < n; i++) begin
      stepClock();
      if (i < a)          expSig = {bE, cE, oE, 1'b0, 1'b0};
      else if (i < a + h) expSig = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      else                expSig = {1'b0, 1'b0, 1'b0, 1'b1, rdE};
      checkOutput($sformatf("%s sig[%0d]", tag, i), 32'({bdir, bc1, ayOe, waitN, cpuOe}),
                  32'(expSig));
      if (expSig[2]) checkOutput($sformatf("%s ay_d[%0d]", tag, i), 32'(ayD), 32'(dE));
      if (!waitN) waitLow++;
    end
    checkOutput({tag, " wait_n low clocks"}, 32'(waitLow), 32'(a + h));
  endtask

  // Release the strobe and confirm the FSM returns quietly to IDLE
  task automatic releaseIdle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, cpuD);
    stepClock();
    checkOutput({tag, " idle sig"}, 32'({bdir, bc1, ayOe, waitN, cpuOe}), 32'(5'b00010));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    ayQ         = 8'h00;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    stepClock();
    stepClock();
    checkOutput("reset sig", 32'({bdir, bc1, ayOe, waitN, cpuOe}), 32'(5'b00010));
    checkOutput("reset ay_d", 32'(ayD), 32'h00);
    checkOutput("reset cpu_q", 32'(cpuQ), 32'hFF);
    reset = 1'b0;

    // Register write 0x07 with the strobe held for 20 clocks: only one latch cycle
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h07);
    runTxn("regwr", 20, 4, 1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07);
    releaseIdle("regwr");

    // Data write 0x3E
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h3E);
    runTxn("datawr", 10, 5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3E);
    releaseIdle("datawr");

    // Data read returning 0xA5
    ayQ = 8'hA5;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    runTxn("datard", 8, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("datard cpu_q", 32'(cpuQ), 32'hA5);
    releaseIdle("datard");
    checkOutput("datard cpu_q held", 32'(cpuQ), 32'hA5);

    // Both strobes low on the data port: write wins, cpu_q untouched
    ayQ = 8'h3C;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
    runTxn("bothlow", 9, 5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    checkOutput("bothlow cpu_q", 32'(cpuQ), 32'hA5);
    releaseIdle("bothlow");

    // Register-port read: no AY cycle, 0xFF returned at once
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    runTxn("regrd", 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("regrd cpu_q", 32'(cpuQ), 32'hFF);
    releaseIdle("regrd");

    // Reset asserted during the second WRITE clock
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h12);
    stepClock();
    checkOutput("rstmid 1st write", 32'({bdir, bc1, ayOe, waitN}), 32'(4'b1010));
    stepClock();
    checkOutput("rstmid 2nd write", 32'({bdir, bc1, ayOe, waitN}), 32'(4'b1010));
    reset = 1'b1;
    stepClock();
    checkOutput("rstmid sig", 32'({bdir, bc1, ayOe, waitN, cpuOe}), 32'(5'b00010));
    checkOutput("rstmid ay_d", 32'(ayD), 32'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    stepClock();
    reset = 1'b0;

    // A fresh data write after reset runs normally
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h66);
    runTxn("postrst", 9, 5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h66);
    releaseIdle("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ay_bus_sequencer.md
# ay_bus_sequencer

Converts decoded CPU I/O accesses to the AY-3-8910 register and data ports into correctly timed AY bus cycles (BDIR/BC1 phases with address/data setup and hold). Holds the Orion PRO CPU in WAIT until each cycle completes. Sits directly downstream of the board port decoder: it consumes the AY register/data chip-selects and the CPU strobes, and drives the AY bus and the WAIT line.

## Interface
Parameters:
- LATCH_CYC, 4: clocks of the address-latch phase (BDIR=1, BC1=1).
- WR_CYC, 5: clocks of the write phase (BDIR=1, BC1=0).
- RD_CYC, 5: clocks of the read phase (BDIR=0, BC1=1).
- HOLD_CYC, 1: inactive clocks after a latch or write phase, with data still driven.

Ports:
- clk in 1: 10 MHz Orion clock; all logic on its rising edge.
- reset in 1: synchronous, active-high.
- cs_reg in 1: decoded select of the AY register-address port.
- cs_data in 1: decoded select of the AY data port.
- rd_n in 1: CPU read strobe, active-low.
- wr_n in 1: CPU write strobe, active-low.
- cpu_d in 8: CPU data bus (write data).
- cpu_q out 8: read data to the CPU.
- cpu_oe out 1: enable for the cpu_q buffer.
- wait_n out 1: CPU WAIT, active-low.
- ay_d out 8: data/address to the AY DA0–DA7 pins.
- ay_oe out 1: enable for the ay_d buffer.
- ay_q in 8: AY DA bus input.
- bdir out 1: AY BDIR.
- bc1 out 1: AY BC1.

## Operation
- Strobe: `stb = (cs_reg | cs_data) & (!rd_n | !wr_n)`. Transaction type is chosen at start:
  - cs_reg & write -> LATCH
  - cs_data & write -> WRITE
  - cs_data & read -> READ
  - cs_reg & read -> REGRD (no AY cycle)
- If rd_n and wr_n are both low, write takes priority.
- If cs_reg and cs_data are both high, cs_data takes priority.
- States: IDLE, LATCH, WRITE, READ, HOLD, DONE.
- IDLE:
  - If stb is seen, register cpu_d into ay_d and load the counter with the phase length minus 1.
  - Go to LATCH, WRITE or READ.
  - For REGRD, load cpu_q <= 8'hFF and go directly to DONE.
- LATCH / WRITE / READ:
  - Outputs are driven from the registered state: LATCH bdir=1 bc1=1; WRITE bdir=1 bc1=0; READ bdir=0 bc1=1.
  - Counter decrements each clock. At counter==0 the phase ends.
  - READ captures cpu_q <= ay_q on its last cycle, then goes to DONE.
  - LATCH and WRITE go to HOLD, with the counter reloaded to HOLD_CYC-1.
- HOLD:
  - bdir=bc1=0; ay_oe stays 1 and ay_d is unchanged.
  - At counter==0, go to DONE.
- DONE:
  - wait_n=1; ay_oe=0.
  - Stay in DONE while stb is high, then go to IDLE. One strobe produces exactly one AY cycle.
- ay_oe = 1 in LATCH, WRITE and HOLD; 0 otherwise.
- wait_n = 0 in LATCH, WRITE, READ and HOLD; 1 otherwise.
- cpu_oe = 1 in DONE while the transaction is READ or REGRD and rd_n=0.
- cpu_q holds its last value until the next READ or REGRD.
- Counter width: $clog2 of the largest parameter, plus 1. All parameters are ≥1; a value of 0 is illegal.
- Strobe changes while not in IDLE or DONE are ignored (the type is already latched).

## Timing
- Reset values: state=IDLE, bdir=0, bc1=0, ay_oe=0, ay_d=0, cpu_q=8'hFF, cpu_oe=0, wait_n=1, counter=0.
- Reset mid-transaction: the next edge forces the reset values. No partial phase continues.
- stb sampled high at edge k -> phase outputs and wait_n=0 are valid after edge k.
- Phase lengths, with outputs active for exactly that many clocks:
  - LATCH: LATCH_CYC, then HOLD_CYC.
  - WRITE: WR_CYC, then HOLD_CYC.
  - READ: RD_CYC, with cpu_q valid from the edge that enters DONE.
- wait_n low duration:
  - LATCH: LATCH_CYC + HOLD_CYC clocks (default 5).
  - WRITE: WR_CYC + HOLD_CYC (default 6).
  - READ: RD_CYC (default 5).
  - REGRD: 0.
- bdir and bc1 never change on the same edge as ay_oe falls. The write-data hold is at least HOLD_CYC clocks.
- Back-to-back accesses: a new transaction starts no earlier than 1 clock after stb falls (DONE -> IDLE -> start).

## Test plan
- Register write of 0x07: exactly 4 clocks of bdir=bc1=1 with ay_d=0x07, then 1 clock of bdir=bc1=0 with ay_oe=1. wait_n is low for 5 clocks. One cycle only, even with the strobe held 20 clocks.
- Data write of 0x3E after the register write: 5 clocks of bdir=1 bc1=0 with ay_d=0x3E, then hold, with wait_n low for 6 clocks. No BC1 pulse.
- Data read with ay_q=0xA5: bc1=1 for 5 clocks, bdir stays 0, ay_oe stays 0. cpu_q=0xA5 and cpu_oe=1 after wait_n rises; cpu_oe=0 after rd_n rises.
- Register-port read: no bdir/bc1 activity, wait_n never low, cpu_q=0xFF with cpu_oe=1.
- reset asserted on the 2nd WRITE clock: the next edge gives bdir=bc1=0, ay_oe=0, wait_n=1, state IDLE. After release, a new data write completes normally.
- rd_n and wr_n both low on cs_data with cpu_d=0x55: a WRITE cycle with ay_d=0x55 occurs, and cpu_q is unchanged.
